// File: rtl/sprite_layer.sv
// sprite_layer: double-buffered sprite slot table with a two-stage
// per-pixel hit/shape pipeline and lowest-index priority.
`ifndef H_DISP_LEN
`define H_DISP_LEN 10
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 9
`endif
`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 12
`endif

module sprite_layer #(
  parameter int SLOTS = 8,
  parameter int SPR_W = 4,
  parameter int SPR_H = 8,
  parameter logic [`COLOR_RGB_DEPTH-1:0] SPR_RGB = 12'hff0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [$clog2(SLOTS)-1:0]    wr_slot_i,
  input  logic                        wr_act_i,
  input  logic [`H_DISP_LEN-1:0]      wr_x_i,
  input  logic [`V_DISP_LEN-1:0]      wr_y_i,
  input  logic                        frame_start_i,
  input  logic                        req_valid_i,
  input  logic [`H_DISP_LEN-1:0]      req_x_addr_i,
  input  logic [`V_DISP_LEN-1:0]      req_y_addr_i,
  output logic [`COLOR_RGB_DEPTH-1:0] rgb_o,
  output logic                        alpha_o,
  output logic [$clog2(SLOTS)-1:0]    hit_slot_o,
  output logic [$clog2(SLOTS):0]      active_cnt_o
);
  localparam int SW  = $clog2(SLOTS);
  localparam int XW  = `H_DISP_LEN;
  localparam int YW  = `V_DISP_LEN;
  localparam int CD  = `COLOR_RGB_DEPTH;
  localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  logic [SLOTS-1:0]          sh_act_q, ac_act_q;
  logic [SLOTS-1:0][XW-1:0]  sh_x_q, ac_x_q;
  logic [SLOTS-1:0][YW-1:0]  sh_y_q, ac_y_q;
  logic [SW:0]               cnt_q, cnt_d;

  logic                      s1_vld_q;
  logic [SLOTS-1:0]          s1_hit_q, s1_hit_d;
  logic [SLOTS-1:0][DXW-1:0] s1_dx_q, s1_dx_d;
  logic [SLOTS-1:0][DYW-1:0] s1_dy_q, s1_dy_d;

  logic [CD-1:0]             rgb_q, rgb_d;
  logic                      alpha_q, alpha_d;
  logic [SW-1:0]             hit_q, hit_d;

  assign wr_ready_o = rst_n & ~frame_start_i;

  // Shadow table takes accepted writes; writes stall during a commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_act_q <= '0;
      sh_x_q   <= '0;
      sh_y_q   <= '0;
    end else if (wr_valid_i && wr_ready_o) begin
      sh_act_q[wr_slot_i] <= wr_act_i;
      sh_x_q[wr_slot_i]   <= wr_x_i;
      sh_y_q[wr_slot_i]   <= wr_y_i;
    end
  end

  // Active table copies the whole shadow table on frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ac_act_q <= '0;
      ac_x_q   <= '0;
      ac_y_q   <= '0;
    end else if (frame_start_i) begin
      ac_act_q <= sh_act_q;
      ac_x_q   <= sh_x_q;
      ac_y_q   <= sh_y_q;
    end
  end

  // Popcount of active slots, registered one cycle behind the table.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < SLOTS; i++)
      cnt_d = cnt_d + (SW+1)'(ac_act_q[i]);
  end

  // Per-slot box test and in-sprite offsets; sums are one bit wider.
  always_comb begin
    logic [XW:0]   xe;
    logic [YW:0]   ye;
    logic [XW-1:0] ddx;
    logic [YW-1:0] ddy;
    s1_hit_d = '0;
    s1_dx_d  = '0;
    s1_dy_d  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      xe  = {1'b0, ac_x_q[i]} + (XW+1)'(SPR_W);
      ye  = {1'b0, ac_y_q[i]} + (YW+1)'(SPR_H);
      ddx = req_x_addr_i - ac_x_q[i];
      ddy = req_y_addr_i - ac_y_q[i];
      s1_hit_d[i] = ac_act_q[i]
                  && (req_x_addr_i >= ac_x_q[i])
                  && ({1'b0, req_x_addr_i} < xe)
                  && (req_y_addr_i >= ac_y_q[i])
                  && ({1'b0, req_y_addr_i} < ye);
      s1_dx_d[i] = ddx[DXW-1:0];
      s1_dy_d[i] = ddy[DYW-1:0];
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_hit_q <= '0;
      s1_dx_q  <= '0;
      s1_dy_q  <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= req_valid_i;
      s1_hit_q <= s1_hit_d;
      s1_dx_q  <= s1_dx_d;
      s1_dy_q  <= s1_dy_d;
      cnt_q    <= cnt_d;
    end
  end

  // Lowest-index box hit wins; its shape bit alone decides coverage.
  always_comb begin
    logic [SW-1:0]    sel;
    logic             any;
    logic [SPR_W-1:0] row;
    logic [DXW-1:0]   col;
    logic             shp;
    sel = '0;
    any = 1'b0;
    for (int i = SLOTS-1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        sel = SW'(i);
        any = 1'b1;
      end
    end
    row = '1;
    if (s1_dy_q[sel] == '0 || s1_dy_q[sel] == DYW'(SPR_H-1)) begin
      row[SPR_W-1] = 1'b0;
      row[0]       = 1'b0;
    end
    col     = DXW'(SPR_W-1) - s1_dx_q[sel];
    shp     = row[col];
    alpha_d = s1_vld_q & any & shp;
    rgb_d   = alpha_d ? SPR_RGB : '0;
    hit_d   = alpha_d ? sel : '0;
  end

  // Stage 2 output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      alpha_q <= 1'b0;
      hit_q   <= '0;
    end else begin
      rgb_q   <= rgb_d;
      alpha_q <= alpha_d;
      hit_q   <= hit_d;
    end
  end

  assign rgb_o        = rgb_q;
  assign alpha_o      = alpha_q;
  assign hit_slot_o   = hit_q;
  assign active_cnt_o = cnt_q;
endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer: scoreboard bench with a table-level reference model,
// directed scenarios followed by randomized traffic.
`ifndef H_DISP_LEN
`define H_DISP_LEN 10
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 9
`endif
`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 12
`endif

module tb_sprite_layer;
  localparam int SLOTS = 8;
  localparam int W = 4;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [2:0]  wr_slot_i = '0;
  logic        wr_act_i = 1'b0;
  logic [9:0]  wr_x_i = '0;
  logic [8:0]  wr_y_i = '0;
  logic        frame_start_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [9:0]  req_x_addr_i = '0;
  logic [8:0]  req_y_addr_i = '0;
  logic [11:0] rgb_o;
  logic        alpha_o;
  logic [2:0]  hit_slot_o;
  logic [3:0]  active_cnt_o;

  sprite_layer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_slot_i(wr_slot_i), .wr_act_i(wr_act_i),
    .wr_x_i(wr_x_i), .wr_y_i(wr_y_i),
    .frame_start_i(frame_start_i),
    .req_valid_i(req_valid_i),
    .req_x_addr_i(req_x_addr_i), .req_y_addr_i(req_y_addr_i),
    .rgb_o(rgb_o), .alpha_o(alpha_o),
    .hit_slot_o(hit_slot_o), .active_cnt_o(active_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  int sh_a[SLOTS], sh_x[SLOTS], sh_y[SLOTS];
  int ac_a[SLOTS], ac_x[SLOTS], ac_y[SLOTS];

  always @(posedge clk) cyc++;

  // Reference pixel: first active slot whose box holds the point;
  // the four box corners are the only transparent shape pixels.
  function automatic logic [15:0] model_pix(input bit rv,
                                            input int rx, input int ry);
    int dx, dy;
    bit corner;
    model_pix = '0;
    if (!rv) return model_pix;
    for (int i = 0; i < SLOTS; i++) begin
      if (ac_a[i] != 0 && rx >= ac_x[i] && rx < ac_x[i] + W
          && ry >= ac_y[i] && ry < ac_y[i] + H) begin
        dx = rx - ac_x[i];
        dy = ry - ac_y[i];
        corner = (dx == 0 || dx == W-1) && (dy == 0 || dy == H-1);
        if (!corner) model_pix = {1'b1, 12'hff0, 3'(i)};
        return model_pix;
      end
    end
  endfunction

  function automatic int popcnt();
    popcnt = 0;
    for (int i = 0; i < SLOTS; i++) popcnt += ac_a[i];
  endfunction

  task automatic step(input bit rst, input bit wv, input int slot,
                      input bit act, input int x, input int y,
                      input bit fs, input bit rv,
                      input int rx, input int ry);
    exp_t e;
    int   ecnt;
    @(negedge clk);
    rst_n         = !rst;
    wr_valid_i    = wv;
    wr_slot_i     = 3'(slot);
    wr_act_i      = act;
    wr_x_i        = 10'(x);
    wr_y_i        = 9'(y);
    frame_start_i = fs;
    req_valid_i   = rv;
    req_x_addr_i  = 10'(rx);
    req_y_addr_i  = 9'(ry);
    e.due = cyc + 2;
    e.v   = rst ? 16'h0 : model_pix(rv, rx, ry);
    if (rst && q.size() > 0 && q[$].due == cyc + 1) q[$].v = '0;
    q.push_back(e);
    ecnt = rst ? 0 : popcnt();
    #1;
    tests++;
    if (wr_ready_o !== (!rst && !fs)) begin
      fails++;
      $display("FAIL ready: got %b want %b", wr_ready_o, !rst && !fs);
    end
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        sh_a[i] = 0; sh_x[i] = 0; sh_y[i] = 0;
        ac_a[i] = 0; ac_x[i] = 0; ac_y[i] = 0;
      end
    end else if (fs) begin
      ac_a = sh_a; ac_x = sh_x; ac_y = sh_y;
    end else if (wv) begin
      sh_a[slot] = act; sh_x[slot] = x; sh_y[slot] = y;
    end
    @(posedge clk);
    #1;
    tests++;
    if (active_cnt_o !== 4'(ecnt)) begin
      fails++;
      $display("FAIL active_cnt: got %0d want %0d", active_cnt_o, ecnt);
    end
  endtask

  task automatic req(input int rx, input int ry);
    step(0, 0, 0, 0, 0, 0, 0, 1, rx, ry);
  endtask

  task automatic wr(input int s, input bit a, input int x, input int y);
    step(0, 1, s, a, x, y, 0, 1, x + 1, y + 1);
  endtask

  task automatic commit();
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic rst_cyc();
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: compare each output against the entry due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        tests++;
        if ({alpha_o, rgb_o, hit_slot_o} !== e.v) begin
          fails++;
          $display("FAIL pixel: got a=%b rgb=%h slot=%0d want a=%b rgb=%h slot=%0d",
                   alpha_o, rgb_o, hit_slot_o, e.v[15], e.v[14:3], e.v[2:0]);
        end
      end
    end
  end

  initial begin
    int x, y, rx, ry;
    for (int i = 0; i < SLOTS; i++) begin
      sh_a[i] = 0; sh_x[i] = 0; sh_y[i] = 0;
      ac_a[i] = 0; ac_x[i] = 0; ac_y[i] = 0;
    end
    rst_cyc();
    rst_cyc();
    // basic hit and transparent corners
    wr(2, 1, 100, 50);
    commit();
    req(101, 50);
    req(100, 50);
    req(103, 57);
    req(102, 57);
    req(104, 50);
    // shadow not visible until commit
    wr(0, 1, 300, 100);
    req(301, 101);
    commit();
    req(301, 101);
    // priority and deactivation
    wr(1, 1, 198, 198);
    wr(5, 1, 199, 196);
    commit();
    req(200, 200);
    wr(1, 0, 198, 198);
    commit();
    req(200, 200);
    wr(1, 1, 200, 200);
    commit();
    req(200, 200);
    // write held across a commit cycle
    step(0, 1, 3, 1, 50, 60, 1, 1, 51, 61);
    step(0, 1, 3, 1, 50, 60, 0, 1, 51, 61);
    req(51, 61);
    commit();
    req(51, 61);
    // right screen edge, no wrap, invalid request
    wr(4, 1, 638, 10);
    commit();
    req(639, 11);
    req(1, 11);
    step(0, 0, 0, 0, 0, 0, 0, 0, 639, 11);
    // reset with active slots and a pending write
    rst_cyc();
    wr(0, 1, 10, 10);
    wr(1, 1, 20, 10);
    wr(2, 1, 30, 10);
    commit();
    req(11, 11);
    wr(6, 1, 40, 40);
    rst_cyc();
    req(11, 11);
    commit();
    req(41, 41);
    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      x  = ($urandom_range(0, 3) == 0) ? $urandom_range(630, 1023)
                                       : $urandom_range(0, 24);
      y  = ($urandom_range(0, 3) == 0) ? $urandom_range(500, 511)
                                       : $urandom_range(0, 24);
      rx = ($urandom_range(0, 3) == 0) ? $urandom_range(630, 1023)
                                       : $urandom_range(0, 30);
      ry = ($urandom_range(0, 3) == 0) ? $urandom_range(500, 511)
                                       : $urandom_range(0, 32);
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, SLOTS-1),
           $urandom_range(0, 3) != 0, x, y,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, rx, ry);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sprite_layer.md
SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 Parameter SLOTS, default 8: number of sprite slots (power of two, 2..16).
REQ-002 Parameter SPR_W, default 4: sprite width in pixels.
REQ-003 Parameter SPR_H, default 8: sprite height in pixels.
REQ-004 Parameter SPR_RGB, default 12'hff0: sprite colour.
REQ-005 The port clk SHALL be an input, 1 bit wide, and is the single clock; every flop is clocked on its rising edge.
REQ-006 The port rst_n SHALL be an input, 1 bit wide, and is a synchronous, active-low reset.
REQ-007 The port wr_valid_i SHALL be an input, 1 bit wide, and signals a slot-write request.
REQ-008 The port wr_ready_o SHALL be an output, 1 bit wide, and signals that the block accepts the write.
REQ-009 The port wr_slot_i SHALL be an input, log2(SLOTS) bits wide, and selects the target slot.
REQ-010 The port wr_act_i SHALL be an input, 1 bit wide, and is the slot-active flag to write.
REQ-011 The port wr_x_i SHALL be an input, `H_DISP_LEN bits wide, and is the sprite top-left x.
REQ-012 The port wr_y_i SHALL be an input, `V_DISP_LEN bits wide, and is the sprite top-left y.
REQ-013 The port frame_start_i SHALL be an input, 1 bit wide, and is a one-cycle pulse that commits the shadow table.
REQ-014 The port req_valid_i SHALL be an input, 1 bit wide, and is the display-active qualifier for the request.
REQ-015 The port req_x_addr_i SHALL be an input, `H_DISP_LEN bits wide, and is the requested pixel x.
REQ-016 The port req_y_addr_i SHALL be an input, `V_DISP_LEN bits wide, and is the requested pixel y.
REQ-017 The port rgb_o SHALL be an output, `COLOR_RGB_DEPTH bits wide, and is the pixel colour.
REQ-018 The port alpha_o SHALL be an output, 1 bit wide, and signals that the pixel is covered by a sprite.
REQ-019 The port hit_slot_o SHALL be an output, log2(SLOTS) bits wide, and is the covering slot index.
REQ-020 The port active_cnt_o SHALL be an output, log2(SLOTS)+1 bits wide, and is the number of active slots in the committed table.

Function
REQ-021 Two tables SHALL be kept: shadow and active, each holding {act, x, y} per slot.
REQ-022 A write SHALL be accepted on a cycle with wr_valid_i=1 and wr_ready_o=1, and its data SHALL be stored in shadow[wr_slot_i] at the next edge.
REQ-023 wr_ready_o SHALL be 1 except on cycles where frame_start_i=1 or rst_n=0.
REQ-024 While wr_ready_o=0, a pending write SHALL be neither dropped nor taken; the sender holds it.
REQ-025 On frame_start_i=1, the active table SHALL load the whole shadow table in one edge, which takes effect for requests sampled from the next cycle onward.
REQ-026 Writes SHALL never alter the active table directly, so there is no tearing mid-frame.
REQ-027 A rewrite of the same slot before a commit SHALL overwrite the shadow entry, with the last write winning.
REQ-028 Pipeline stage 1 (registered) SHALL compute, per slot i, hit_i = act_i AND x_i<=req_x<x_i+SPR_W AND y_i<=req_y<y_i+SPR_H, and SHALL register dx=req_x-x_i and dy=req_y-y_i for each slot together with req_valid_i.
REQ-029 Coordinate sums SHALL be computed one bit wider than the operands, with no wrap-around; a sprite extending past the screen edge is clipped.
REQ-030 Pipeline stage 2 (registered) SHALL select the lowest-index slot with a hit, look up the shape bit ROM[dy][SPR_W-1-dx], and register the outputs.
REQ-031 Default shape (4x8): rows 0 and 7 = 0110; rows 1-6 = 1111.
REQ-032 alpha_o SHALL be (stage-1 valid AND any hit on the selected slot AND shape bit); rgb_o SHALL be SPR_RGB when alpha_o=1 and 12'h000 otherwise.
REQ-033 hit_slot_o SHALL be the selected index when alpha_o=1 and 0 otherwise.
REQ-034 Transparent shape pixels SHALL NOT fall through to a higher-index slot; the selection is on box hit only.
REQ-035 Latency from request to output SHALL be exactly 2 cycles; the pipeline is fully pipelined, one request per cycle, with no stall.
REQ-036 active_cnt_o SHALL be a registered popcount of the active act bits, updated one cycle after a commit.

Reset
REQ-037 While rst_n=0 at an edge, all shadow and active entries SHALL be cleared (act=0, x=0, y=0), pipeline valids cleared, rgb_o=0, alpha_o=0, hit_slot_o=0, active_cnt_o=0, and wr_ready_o=0.
REQ-038 Reset asserted mid-frame SHALL discard any uncommitted writes, and the first output after release SHALL be alpha_o=0.

Verification
REQ-039 Write slot 2 {act=1, x=100, y=50}, pulse frame_start_i, request (101,50) -> 2 cycles later alpha_o=1, rgb_o=12'hff0, hit_slot_o=2; request (100,50) -> alpha_o=0 (corner transparent).
REQ-040 Write slot 0 without a commit, request inside the box -> alpha_o=0; after frame_start_i, the same request -> alpha_o=1.
REQ-041 Slots 1 and 5 overlap at (200,200), with a request there -> hit_slot_o=1; deactivate slot 1 and commit -> hit_slot_o=5.
REQ-042 wr_valid_i held on a frame_start_i cycle -> wr_ready_o=0 that cycle, the write lands on the following cycle, and it is not in the active table until the next commit.
REQ-043 Sprite x=638 (width 640) and request x=639 -> hit; request x=1 -> no hit (no wrap); req_valid_i=0 -> alpha_o=0.
REQ-044 Activate 3 slots, commit, then assert rst_n=0 for one cycle -> active_cnt_o goes 3 then 0, and all outputs are 0.
